i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, default 25'h100000, first SDRAM word address of the capture buffer; BUF_LEN, default 4096, buffer length in 16-bit words; FIFO_DEPTH, default 16, internal sample FIFO depth (power of 2).
REQ-002 Clk50  in  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SClk  in  1  I2S bit clock from the codec; asynchronous to Clk50; at most Clk50/8.
REQ-005 LRClk  in  1  I2S word select; 0 = left, 1 = right.
REQ-006 Din  in  1  I2S serial data from the codec ADC, MSB first.
REQ-007 enable  in  1  level; 1 = capture and store.
REQ-008 sdram_Wait  in  1  1 = SDRAM controller cannot accept a request.
REQ-009 sdram_ac  in  1  one-cycle acknowledge that the current write has been accepted.
REQ-010 sdram_wr  out  1  write request, held until acknowledged.
REQ-011 sdram_addr  out  25  word address of the current write.
REQ-012 sdram_wdata  out  16  sample data of the current write.
REQ-013 busy  out  1  1 while an SDRAM write is outstanding.
REQ-014 sample_valid  out  1  one-cycle pulse per completed 16-bit word.
REQ-015 overflow  out  1  sticky flag, set when a sample is dropped.
REQ-016 wrap  out  1  one-cycle pulse when sdram_addr wraps to BASE_ADDR.
REQ-017 fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-018 SClk, LRClk and Din SHALL each pass through a 2-flop synchronizer; the SClk rising edge SHALL be detected from the synchronized history; Din and LRClk SHALL be sampled at that same detected edge.
REQ-019 A change of synchronized LRClk at a detected SClk edge SHALL set the bit counter to 0; each later SClk edge SHALL increment the counter, saturating at 31.
REQ-020 The counter-0 bit SHALL be ignored (I2S one-bit delay); bits at counts 1..16 SHALL be shifted in MSB first; bits at counts 17..31 SHALL be ignored.
REQ-021 At count 16, the word SHALL be complete; sample_valid SHALL pulse in the next cycle; the word SHALL be pushed to the FIFO in that same cycle.
REQ-022 Capture SHALL begin only at the first LRClk 1->0 transition after enable rises, so the buffer always starts with a left sample and holds strict L,R alternation.
REQ-023 A push to a full FIFO SHALL drop the word, leave the FIFO unchanged, and set overflow; overflow SHALL clear only on reset or on enable 1->0.
REQ-024 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a full FIFO with a simultaneous pop SHALL accept the push.
REQ-025 The write FSM SHALL have states IDLE, REQ, ACK.
REQ-026 IDLE->REQ SHALL occur when the FIFO is non-empty and sdram_Wait=0; on entry, sdram_wdata SHALL load the FIFO head; sdram_wr and busy SHALL be 1 throughout REQ.
REQ-027 In REQ, sdram_addr and sdram_wdata SHALL stay stable until sdram_ac=1; REQ->ACK SHALL occur on sdram_ac.
REQ-028 In ACK (one cycle), the FSM SHALL pop the FIFO, set sdram_wr=0, and advance the address, then return to IDLE; minimum spacing is 3 cycles per word.
REQ-029 Address advance SHALL be +1, except sdram_addr = BASE_ADDR+BUF_LEN-1, which SHALL return to BASE_ADDR and pulse wrap.
REQ-030 On enable 1->0, capture SHALL stop immediately and discard the partial word; an outstanding write SHALL complete; the FIFO SHALL drain to SDRAM; sdram_addr SHALL NOT reset.
REQ-031 sdram_ac outside REQ SHALL be ignored.

Reset
REQ-032 reset_n=0 SHALL asynchronously force: FSM IDLE, FIFO empty, bit counter 0, capture disarmed, sdram_wr=0, busy=0, sample_valid=0, wrap=0, overflow=0, fifo_count=0, sdram_wdata=0, sdram_addr=BASE_ADDR.
REQ-033 Reset during REQ SHALL abandon the write with no pop; after reset release, operation SHALL resume from BASE_ADDR.

Verification
REQ-034 Single frame: SClk = Clk50/16; enable=1; left=16'hA5C3, right=16'h3C5A; sdram_Wait=0; ac 2 cycles after wr -> writes 16'hA5C3 @25'h100000, then 16'h3C5A @25'h100001; two sample_valid pulses.
REQ-035 Enable mid-right-channel: enable=1 while LRClk=1 -> the right word is ignored; the first stored word is the next left word.
REQ-036 Overflow: sdram_Wait=1 for 20 words -> fifo_count=16, overflow=1, words 17-20 lost; release -> 16 writes in order, overflow stays 1.
REQ-037 Wrap: BUF_LEN=4, 6 words -> addresses 100000,100001,100002,100003,100000,100001; one wrap pulse on the 4th ack.
REQ-038 Reset mid-write: reset_n=0 in REQ -> sdram_wr=0 immediately, fifo_count=0; the next write after release targets 25'h100000.
REQ-039 Delay slot / long slot: 32-bit slots with Din=1 at count 0 and counts 17..31 -> the stored word is exactly bits 1..16.

Source files
------------

// File: rtl/i2s_rx_if.sv
// SDRAM write-port bundle between the I2S capture block and the SDRAM controller.
interface i2s_rx_if;
  logic        sdram_Wait;
  logic        sdram_ac;
  logic        sdram_wr;
  logic [24:0] sdram_addr;
  logic [15:0] sdram_wdata;

  // Capture block issues writes.
  modport master (
    input  sdram_Wait,
    input  sdram_ac,
    output sdram_wr,
    output sdram_addr,
    output sdram_wdata
  );

  // SDRAM controller side.
  modport slave (
    output sdram_Wait,
    output sdram_ac,
    input  sdram_wr,
    input  sdram_addr,
    input  sdram_wdata
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the codec bit stream, assembles 16-bit words, buffers them in a
// small FIFO and writes them to a circular buffer in SDRAM.
module i2s_rx #(
  parameter logic [24:0] BASE_ADDR  = 25'h100000,
  parameter int unsigned BUF_LEN    = 4096,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        Clk50,
  input  logic                        reset_n,
  input  logic                        SClk,
  input  logic                        LRClk,
  input  logic                        Din,
  input  logic                        enable,
  i2s_rx_if.master                    sdram,
  output logic                        busy,
  output logic                        sample_valid,
  output logic                        overflow,
  output logic                        wrap,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [24:0] LastAddr  = BASE_ADDR + 25'(BUF_LEN - 1);

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  // ---------------------------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------------------------
  logic [1:0] sclk_sync_q, lr_sync_q, din_sync_q;
  logic       sclk_prev_q;
  logic       sclk_rise;
  logic       lr_s, din_s;

  // Two-flop synchronizers plus one history flop for SClk edge detection.
  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], SClk};
      lr_sync_q   <= {lr_sync_q[0], LRClk};
      din_sync_q  <= {din_sync_q[0], Din};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign lr_s      = lr_sync_q[1];
  assign din_s     = din_sync_q[1];

  // ---------------------------------------------------------------------------------------------
  // Bit counter, shift register and capture arming
  // ---------------------------------------------------------------------------------------------
  logic        lr_q, lr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        capture_q, capture_d;
  logic        word_done;
  logic        sample_valid_q;
  logic        enable_q;

  // Slot tracking: LR change restarts the count; count 0 is the I2S delay bit.
  always_comb begin
    lr_d      = lr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    capture_d = capture_q;
    word_done = 1'b0;
    if (sclk_rise) begin
      lr_d = lr_s;
      if (lr_s != lr_q) begin
        bit_cnt_d = 5'd0;
      end else if (bit_cnt_q != 5'd31) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
      if (bit_cnt_d >= 5'd1 && bit_cnt_d <= 5'd16) begin
        shift_d = {shift_q[14:0], din_s};
      end
      // Arm only on a right->left boundary so the buffer starts with a left word.
      if (enable && lr_q && !lr_s) begin
        capture_d = 1'b1;
      end
      if (capture_q && enable && bit_cnt_d == 5'd16) begin
        word_done = 1'b1;
      end
    end
    if (!enable) begin
      capture_d = 1'b0;
    end
  end

  // Capture state registers.
  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      lr_q           <= 1'b0;
      bit_cnt_q      <= 5'd0;
      shift_q        <= '0;
      capture_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      enable_q       <= 1'b0;
    end else begin
      lr_q           <= lr_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      capture_q      <= capture_d;
      sample_valid_q <= word_done;
      enable_q       <= enable;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------------------------
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            push, pop, push_ok, full;
  logic            overflow_q, overflow_d;

  assign push    = sample_valid_q;
  assign full    = (count_q == FullCnt);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop);

  // Occupancy and sticky overflow; overflow clears when enable falls.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
    if (enable_q && !enable) begin
      overflow_d = 1'b0;
    end else if (push && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO pointers and flags.
  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge Clk50) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // SDRAM write FSM
  // ---------------------------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [24:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wrap_q, wrap_d;

  // Next state: latch the FIFO head on entry to REQ, pop and advance the address in ACK.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wrap_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && !sdram.sdram_Wait) begin
          state_d = StReq;
          wdata_d = mem_q[rd_ptr_q];
        end
      end
      StReq: begin
        if (sdram.sdram_ac) begin
          state_d = StAck;
        end
      end
      StAck: begin
        pop     = 1'b1;
        state_d = StIdle;
        if (addr_q == LastAddr) begin
          addr_d = BASE_ADDR;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q + 25'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write FSM registers; reset abandons any write in flight.
  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sdram.sdram_wr    = (state_q == StReq);
  assign sdram.sdram_addr  = addr_q;
  assign sdram.sdram_wdata = wdata_q;
  assign busy              = (state_q == StReq);
  assign sample_valid      = sample_valid_q;
  assign overflow          = overflow_q;
  assign wrap              = wrap_q;
  assign fifo_count        = count_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives randomized I2S frames, models the capture rules at slot level and
// compares SDRAM writes recorded by a simple controller model.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam logic [24:0] Base   = 25'h100000;
  localparam int unsigned BufLen = 4;
  localparam int unsigned Depth  = 16;

  logic       Clk50, reset_n, SClk, LRClk, Din, enable;
  logic       busy, sample_valid, overflow, wrap;
  logic [4:0] fifo_count;
  logic       wait_r, resp_ac, stray_ac;

  i2s_rx_if sif ();
  assign sif.sdram_Wait = wait_r;
  assign sif.sdram_ac   = resp_ac | stray_ac;

  i2s_rx #(
    .BASE_ADDR (Base),
    .BUF_LEN   (BufLen),
    .FIFO_DEPTH(Depth)
  ) dut (
    .Clk50       (Clk50),
    .reset_n     (reset_n),
    .SClk        (SClk),
    .LRClk       (LRClk),
    .Din         (Din),
    .enable      (enable),
    .sdram       (sif),
    .busy        (busy),
    .sample_valid(sample_valid),
    .overflow    (overflow),
    .wrap        (wrap),
    .fifo_count  (fifo_count)
  );

  initial Clk50 = 1'b0;
  always #10 Clk50 = ~Clk50;

  int checks, passes;

  // SDRAM controller model state and write log.
  logic        resp_en;
  int          ac_delay;  // negative selects a random delay per write
  int          stable_err;
  logic [24:0] wq_addr[$];
  logic [15:0] wq_data[$];

  // Slot-level capture model.
  logic [15:0] exp_data[$];
  bit          model_armed, model_prev_lr;

  int sv_cnt, wrap_cnt;

  function automatic logic [24:0] model_addr(input int n);
    return Base + 25'(n % BufLen);
  endfunction

  // Controller model: acknowledges each request after a delay, logging and checking stability.
  initial begin : sdram_model
    bit          in_req;
    int          left;
    logic [24:0] ha;
    logic [15:0] hd;
    in_req  = 0;
    left    = 0;
    ha      = '0;
    hd      = '0;
    resp_ac = 1'b0;
    forever begin
      @(negedge Clk50);
      resp_ac = 1'b0;
      if (sif.sdram_wr !== 1'b1) begin
        in_req = 0;
      end else if (resp_en) begin
        if (!in_req) begin
          in_req = 1;
          ha     = sif.sdram_addr;
          hd     = sif.sdram_wdata;
          left   = (ac_delay < 0) ? int'($urandom_range(0, 3)) : ac_delay;
        end else if (sif.sdram_addr !== ha || sif.sdram_wdata !== hd) begin
          stable_err++;
        end
        if (left == 0) begin
          resp_ac = 1'b1;
          wq_addr.push_back(ha);
          wq_data.push_back(hd);
          in_req = 0;
        end else begin
          left--;
        end
      end
    end
  end

  // Pulse counters.
  initial begin : pulse_mon
    forever begin
      @(negedge Clk50);
      if (sample_valid === 1'b1) sv_cnt++;
      if (wrap === 1'b1) wrap_cnt++;
    end
  end

  task automatic send_bit(input logic lr, input logic b);
    LRClk = lr;
    Din   = b;
    repeat (8) @(negedge Clk50);
    SClk = 1'b1;
    repeat (8) @(negedge Clk50);
    SClk = 1'b0;
  endtask

  // One slot of nbits; fill drives the delay bit and the bits after the word.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits,
                           input logic fill, input int en_bit, input logic en_val);
    bit   expect_it;
    logic b;
    if (!enable) model_armed = 0;
    else if (model_prev_lr && !lr) model_armed = 1;
    expect_it = model_armed && enable;
    for (int i = 0; i < nbits; i++) begin
      if (i == en_bit) begin
        enable = en_val;
        if (!en_val) begin
          expect_it   = 0;
          model_armed = 0;
        end
      end
      if (i >= 1 && i <= 16) b = w[16-i];
      else b = fill;
      send_bit(lr, b);
    end
    if (expect_it) exp_data.push_back(w);
    model_prev_lr = lr;
  endtask

  task automatic send_frames(input int n, input int nbits, input logic fill);
    for (int k = 0; k < n; k++) begin
      send_slot(1'b0, 16'($urandom), nbits, fill, -1, 1'b0);
      send_slot(1'b1, 16'($urandom), nbits, fill, -1, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    wait_r   = 1'b0;
    stray_ac = 1'b0;
    resp_en  = 1'b1;
    ac_delay = -1;
    SClk     = 1'b0;
    repeat (3) @(negedge Clk50);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk50);
    wq_addr.delete();
    wq_data.delete();
    exp_data.delete();
    sv_cnt        = 0;
    wrap_cnt      = 0;
    stable_err    = 0;
    model_armed   = 0;
    model_prev_lr = 0;
  endtask

  task automatic wait_writes(input int n);
    int budget = 3000;
    while (wq_data.size() < n && budget > 0) begin
      @(negedge Clk50);
      budget--;
    end
    repeat (6) @(negedge Clk50);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge Clk50);
    checks++; if (sif.sdram_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", sif.sdram_wr); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid); else passes++;
    checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passes++;
    checks++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passes++;
    checks++; if (sif.sdram_wdata !== 16'h0) $display("FAIL reset_wdata: got %h want 0", sif.sdram_wdata); else passes++;
    checks++; if (sif.sdram_addr !== Base) $display("FAIL reset_addr: got %h want %h", sif.sdram_addr, Base); else passes++;
  endtask

  task automatic test_single_frame();
    do_reset();
    enable   = 1'b1;
    ac_delay = 2;
    send_slot(1'b1, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_slot(1'b0, 16'hA5C3, 20, 1'b0, -1, 1'b0);
    send_slot(1'b1, 16'h3C5A, 20, 1'b0, -1, 1'b0);
    wait_writes(2);
    checks++; if (wq_data.size() !== 2) $display("FAIL single_nwr: got %0d want 2", wq_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL single_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
    checks++; if (sv_cnt !== 2) $display("FAIL single_valid: got %0d pulses want 2", sv_cnt); else passes++;
    checks++; if (stable_err !== 0) $display("FAIL single_stable: got %0d changes want 0", stable_err); else passes++;
  endtask

  task automatic test_wrap();
    int exp_wraps;
    do_reset();
    enable = 1'b1;
    send_slot(1'b1, 16'($urandom), 20, 1'b1, -1, 1'b0);
    send_frames(3, 20, 1'b0);
    wait_writes(6);
    exp_wraps = 0;
    for (int n = 0; n < exp_data.size(); n++) if (n % BufLen == BufLen - 1) exp_wraps++;
    checks++; if (wq_data.size() !== 6) $display("FAIL wrap_nwr: got %0d want 6", wq_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL wrap_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
    checks++; if (wrap_cnt !== exp_wraps) $display("FAIL wrap_pulses: got %0d want %0d", wrap_cnt, exp_wraps); else passes++;
    checks++; if (sif.sdram_addr !== model_addr(6)) $display("FAIL wrap_addr: got %h want %h", sif.sdram_addr, model_addr(6)); else passes++;
    checks++; if (stable_err !== 0) $display("FAIL wrap_stable: got %0d changes want 0", stable_err); else passes++;
  endtask

  task automatic test_enable_mid_right();
    do_reset();
    send_slot(1'b0, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_slot(1'b1, 16'($urandom), 20, 1'b0, 6, 1'b1);
    send_frames(1, 20, 1'b0);
    wait_writes(2);
    checks++; if (wq_data.size() !== 2) $display("FAIL midr_nwr: got %0d want 2", wq_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL midr_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
    checks++; if (sv_cnt !== 2) $display("FAIL midr_valid: got %0d pulses want 2", sv_cnt); else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    wait_r = 1'b1;
    send_slot(1'b1, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_frames(10, 20, 1'b0);
    repeat (4) @(negedge Clk50);
    checks++; if (fifo_count !== 5'(Depth)) $display("FAIL ovf_count: got %0d want %0d", fifo_count, Depth); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passes++;
    checks++; if (sv_cnt !== 20) $display("FAIL ovf_valid: got %0d pulses want 20", sv_cnt); else passes++;
    checks++; if (wq_data.size() !== 0) $display("FAIL ovf_held: got %0d writes want 0", wq_data.size()); else passes++;
    wait_r = 1'b0;
    wait_writes(Depth);
    checks++; if (wq_data.size() !== Depth) $display("FAIL ovf_nwr: got %0d want %0d", wq_data.size(), Depth); else passes++;
    for (int i = 0; i < Depth && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL ovf_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passes++;
    enable = 1'b0;
    repeat (2) @(negedge Clk50);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else passes++;
  endtask

  task automatic test_long_slot();
    do_reset();
    enable = 1'b1;
    send_slot(1'b1, 16'($urandom), 32, 1'b1, -1, 1'b0);
    send_frames(2, 32, 1'b1);
    wait_writes(4);
    checks++; if (wq_data.size() !== 4) $display("FAIL long_nwr: got %0d want 4", wq_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i])
        $display("FAIL long_wr%0d: got %h want %h", i, wq_data[i], exp_data[i]);
      else passes++;
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    wait_r = 1'b1;
    send_slot(1'b1, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_frames(1, 20, 1'b0);
    send_slot(1'b0, 16'($urandom), 20, 1'b1, 8, 1'b0);
    wait_r = 1'b0;
    wait_writes(3);
    checks++; if (wq_data.size() !== exp_data.size()) $display("FAIL drop_nwr: got %0d want %0d", wq_data.size(), exp_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL drop_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
    checks++; if (fifo_count !== 5'd0) $display("FAIL drop_count: got %0d want 0", fifo_count); else passes++;
    checks++; if (sif.sdram_addr !== model_addr(2)) $display("FAIL drop_addr: got %h want %h", sif.sdram_addr, model_addr(2)); else passes++;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    enable  = 1'b1;
    resp_en = 1'b0;
    send_slot(1'b1, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_slot(1'b0, 16'($urandom), 20, 1'b0, -1, 1'b0);
    repeat (4) @(negedge Clk50);
    checks++; if (busy !== 1'b1) $display("FAIL rmw_busy: got %b want 1", busy); else passes++;
    checks++; if (fifo_count !== 5'd1) $display("FAIL rmw_count: got %0d want 1", fifo_count); else passes++;
    #5 reset_n = 1'b0;
    #1;
    checks++; if (sif.sdram_wr !== 1'b0) $display("FAIL rmw_wr: got %b want 0", sif.sdram_wr); else passes++;
    checks++; if (fifo_count !== 5'd0) $display("FAIL rmw_flush: got %0d want 0", fifo_count); else passes++;
    checks++; if (sif.sdram_addr !== Base) $display("FAIL rmw_addr: got %h want %h", sif.sdram_addr, Base); else passes++;
    do_reset();
    enable = 1'b1;
    send_slot(1'b1, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_frames(1, 20, 1'b0);
    wait_writes(2);
    checks++; if (wq_data.size() !== 2) $display("FAIL rmw_nwr: got %0d want 2", wq_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL rmw_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
  endtask

  task automatic test_stray_ac();
    do_reset();
    stray_ac = 1'b1;
    repeat (3) @(negedge Clk50);
    stray_ac = 1'b0;
    repeat (2) @(negedge Clk50);
    checks++; if (sif.sdram_wr !== 1'b0) $display("FAIL stray_wr: got %b want 0", sif.sdram_wr); else passes++;
    checks++; if (sif.sdram_addr !== Base) $display("FAIL stray_addr: got %h want %h", sif.sdram_addr, Base); else passes++;
    enable = 1'b1;
    send_slot(1'b1, 16'($urandom), 20, 1'b0, -1, 1'b0);
    send_frames(1, 20, 1'b1);
    wait_writes(2);
    checks++; if (wq_data.size() !== 2) $display("FAIL stray_nwr: got %0d want 2", wq_data.size()); else passes++;
    for (int i = 0; i < exp_data.size() && i < wq_data.size(); i++) begin
      checks++;
      if (wq_data[i] !== exp_data[i] || wq_addr[i] !== model_addr(i))
        $display("FAIL stray_wr%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], model_addr(i));
      else passes++;
    end
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    sv_cnt     = 0;
    wrap_cnt   = 0;
    stable_err = 0;
    reset_n    = 1'b0;
    SClk       = 1'b0;
    LRClk      = 1'b1;
    Din        = 1'b0;
    enable     = 1'b0;
    wait_r     = 1'b0;
    stray_ac   = 1'b0;
    resp_en    = 1'b1;
    ac_delay   = -1;
    @(negedge Clk50);
    test_reset();
    test_single_frame();
    test_wrap();
    test_enable_mid_right();
    test_overflow();
    test_long_slot();
    test_enable_drop();
    test_reset_mid_write();
    test_stray_ac();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
